// File: rtl/hs_seq_source_if.sv
// hs_intf: valid/ready handshake bundle carrying one WIDTH-bit data beat
// plus an end-of-burst marker.
//   valid : source has a beat on data/last
//   ready : sink accepts the beat on this edge when valid is high
//   data  : beat payload, WIDTH bits
//   last  : marks the final beat of a burst
// Modports: src (transmitting end), snk (receiving end).
interface hs_intf #(
    parameter int unsigned WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport src (output valid, output data, output last, input ready);
    modport snk (input valid, input data, input last, output ready);
endinterface

// File: rtl/hs_seq_source.sv
// hs_seq_source: on a one-cycle start pulse, transmits NUM_BEATS beats of the
// arithmetic sequence SEED, SEED+STEP, ... (mod 2^WIDTH) over an hs_intf
// source port, flags the final beat with last, pulses done after the final
// handshake and counts back-pressure cycles.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle burst request, ignored unless idle
//   bus       : hs_intf.src; drives valid/data/last, samples ready
//   busy      : high while beats are being offered
//   done      : one-cycle pulse after the final handshake
//   stall_cnt : valid && !ready cycles in the current/most recent burst
module hs_seq_source #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      NUM_BEATS = 4,
    parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] STEP      = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    hs_intf.src         bus,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cnt
);
    localparam int unsigned    IW       = $clog2(NUM_BEATS + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_BEATS - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             last_r, last_s;
    logic [15:0]      stall_r, stall_s;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;

    // Next-state and next-datapath values; every output is registered from these.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        data_s  = data_r;
        last_s  = last_r;
        stall_s = stall_r;
        case (state_r)
            S_IDLE: begin
                // Burst context is (re)initialised on the accepting edge so the
                // previous burst's stall count stays readable while idle.
                if (start) begin
                    state_s = S_SEND;
                    idx_s   = {IW{1'b0}};
                    data_s  = SEED;
                    last_s  = (LAST_IDX == {IW{1'b0}});
                    stall_s = 16'h0000;
                end else begin
                    last_s  = 1'b0;
                end
            end
            S_SEND: begin
                if (bus.ready) begin
                    if (last_r) begin
                        state_s = S_DONE;
                        last_s  = 1'b0;
                    end else begin
                        idx_s  = idx_r + IDX_ONE;
                        data_s = data_r + STEP;
                        last_s = ((idx_r + IDX_ONE) == LAST_IDX);
                    end
                end else begin
                    // Beat is held; only the back-pressure counter moves.
                    if (stall_r != 16'hFFFF) begin
                        stall_s = stall_r + 16'd1;
                    end else begin
                        stall_s = stall_r;
                    end
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                last_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset abandons any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            idx_r   <= {IW{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            last_r  <= 1'b0;
            stall_r <= 16'h0000;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            data_r  <= data_s;
            last_r  <= last_s;
            stall_r <= stall_s;
            valid_r <= (state_s == S_SEND);
            busy_r  <= (state_s == S_SEND);
            done_r  <= (state_s == S_DONE);
        end
    end

    assign bus.valid = valid_r;
    assign bus.data  = data_r;
    assign bus.last  = last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_hs_seq_source.sv
// tb_hs_seq_source: four differently parameterised hs_seq_source instances,
// each bound to its own hs_intf, share start/rst_n but get independent ready.
// A burst-level reference model pushes expected beats and stall counts into
// per-instance queues; a negedge monitor pops and compares.
module tb_hs_seq_source;
    localparam int NCFG = 4;
    localparam int         NB_A   [NCFG] = '{4, 4, 1, 5};
    localparam logic [7:0] SEED_A [NCFG] = '{8'h10, 8'hFE, 8'hA5, 8'h37};
    localparam logic [7:0] STEP_A [NCFG] = '{8'h01, 8'h01, 8'h01, 8'h53};

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [NCFG-1:0] ready_v = '0;
    logic [NCFG-1:0] valid_v, last_v, busy_v, done_v;
    logic [7:0]      data_v  [NCFG];
    logic [15:0]     stall_v [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        hs_intf #(.WIDTH(8)) bus ();
        hs_seq_source #(
            .WIDTH(8), .NUM_BEATS(NB_A[g]), .SEED(SEED_A[g]), .STEP(STEP_A[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
            .busy(busy_v[g]), .done(done_v[g]), .stall_cnt(stall_v[g])
        );
        assign bus.ready  = ready_v[g];
        assign valid_v[g] = bus.valid;
        assign last_v[g]  = bus.last;
        assign data_v[g]  = bus.data;
    end

    // Reference model state (written only by the stimulus process)
    int          phase  [NCFG];   // 0 idle, 1 sending, 2 done cycle
    int          left   [NCFG];
    int unsigned stalls [NCFG];
    logic        exp_valid [NCFG];
    logic        exp_done  [NCFG];
    logic [8:0]  beat_q  [NCFG][$];
    int unsigned stall_q [NCFG][$];
    bit          stim_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_clear();
        for (int g = 0; g < NCFG; g++) begin
            phase[g] = 0; left[g] = 0; stalls[g] = 0;
            exp_valid[g] = 1'b0; exp_done[g] = 1'b0;
            beat_q[g].delete(); stall_q[g].delete();
        end
    endtask

    // Advance the model over one rising edge with the inputs present at it.
    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int g = 0; g < NCFG; g++) begin
                if (phase[g] == 2) begin
                    phase[g] = 0;
                end else if (phase[g] == 1) begin
                    if (ready_v[g]) begin
                        left[g]--;
                        if (left[g] == 0) begin
                            phase[g] = 2;
                            stall_q[g].push_back(stalls[g]);
                        end
                    end else begin
                        stalls[g]++;
                    end
                end else if (start) begin
                    phase[g]  = 1;
                    left[g]   = NB_A[g];
                    stalls[g] = 0;
                    for (int i = 0; i < NB_A[g]; i++) begin
                        logic [7:0] v;
                        v = 8'((int'(SEED_A[g]) + i * int'(STEP_A[g])) % 256);
                        beat_q[g].push_back({(i == NB_A[g] - 1), v});
                    end
                end
                exp_valid[g] = (phase[g] == 1);
                exp_done[g]  = (phase[g] == 2);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic [NCFG-1:0] rd);
        @(posedge clk);
        model_edge();
        #2;
        rst_n   = r;
        start   = s;
        ready_v = rd;
        if (!r) model_clear();
    endtask

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic pat [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        model_clear();
        #1 rst_n = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '1);
        // back-to-back burst with ready held high
        cycle(1'b1, 1'b1, '1);
        repeat (8) cycle(1'b1, 1'b0, '1);
        // back-pressure pattern with extra starts while busy and in DONE
        cycle(1'b1, 1'b1, '1);
        for (int k = 0; k < 7; k++) cycle(1'b1, (k == 1), {NCFG{pat[k]}});
        cycle(1'b1, 1'b1, '1);
        repeat (8) cycle(1'b1, 1'b0, '1);
        // mid-burst reset after beat 1 is accepted, then restart
        cycle(1'b1, 1'b1, '1);
        cycle(1'b1, 1'b0, '1);
        cycle(1'b1, 1'b0, '1);
        cycle(1'b0, 1'b0, '1);
        cycle(1'b0, 1'b0, '1);
        cycle(1'b1, 1'b0, '1);
        cycle(1'b1, 1'b1, '1);
        repeat (8) cycle(1'b1, 1'b0, '1);
        // randomized traffic with occasional resets
        repeat (1500) begin
            logic r;
            logic s;
            r = ($urandom_range(0, 299) != 0);
            s = ($urandom_range(0, 4) == 0);
            cycle(r, s, NCFG'($urandom));
        end
        repeat (12) cycle(1'b1, 1'b0, '1);
        stim_done = 1'b1;
    end

    task automatic chk(input bit ok, input string name, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the model away from the clock edge.
    always @(negedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            if (!rst_n) begin
                chk(!valid_v[g] && !last_v[g] && data_v[g] == 8'h00 && !busy_v[g]
                    && !done_v[g] && stall_v[g] == 16'h0000, "reset_outputs", g,
                    {valid_v[g], last_v[g], busy_v[g], done_v[g], data_v[g], stall_v[g]}, 32'h0);
            end else begin
                chk(valid_v[g] == exp_valid[g], "valid", g, 32'(valid_v[g]), 32'(exp_valid[g]));
                chk(busy_v[g] == exp_valid[g], "busy", g, 32'(busy_v[g]), 32'(exp_valid[g]));
                chk(done_v[g] == exp_done[g], "done", g, 32'(done_v[g]), 32'(exp_done[g]));
                if (valid_v[g]) begin
                    if (beat_q[g].size() == 0) begin
                        chk(1'b0, "unexpected_beat", g, {23'h0, last_v[g], data_v[g]}, 32'h0);
                    end else begin
                        chk({last_v[g], data_v[g]} == beat_q[g][0], "beat", g,
                            {23'h0, last_v[g], data_v[g]}, {23'h0, beat_q[g][0]});
                        if (ready_v[g]) void'(beat_q[g].pop_front());
                    end
                end
                if (done_v[g]) begin
                    chk(beat_q[g].size() == 0, "beats_left_at_done", g,
                        32'(beat_q[g].size()), 32'h0);
                    if (stall_q[g].size() == 0) begin
                        chk(1'b0, "unexpected_done", g, 32'(stall_v[g]), 32'h0);
                    end else begin
                        chk(32'(stall_v[g]) == stall_q[g][0], "stall_cnt", g,
                            32'(stall_v[g]), stall_q[g][0]);
                        void'(stall_q[g].pop_front());
                    end
                end
            end
        end
        if (stim_done) begin
            for (int g = 0; g < NCFG; g++) begin
                chk(beat_q[g].size() == 0 && stall_q[g].size() == 0, "drain", g,
                    32'(beat_q[g].size() + stall_q[g].size()), 32'h0);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end
endmodule
